uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel stage downstream of the transmitter: recovers 8N1 frames from the RxD line and presents each byte with a one-cycle valid strobe.
- Used for transmitter loopback tests on the board and as the receive half of the UART.
- Samples each bit at mid-bit, timed from a clock-cycle counter derived from CLK_FREQ and BAUD.
- Flags frames whose stop bit is low.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s. BIT_TICKS = CLK_FREQ/BAUD (integer division). HALF_TICKS = BIT_TICKS/2. Both must be at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line; idles high.
- data  output  8  last correctly received byte; holds its value between frames.
- valid  output  1  one-cycle pulse; data is new on this cycle.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, synchronous: state=IDLE, counter=0, bit index=0, shift register=0, data=8'h00, valid=0, framing_error=0, busy=0. Both synchronizer flops are set to 1, which is the idle level.
- RxD passes through a 2-flop synchronizer and is called rx_s below. Every decision uses rx_s only.
- IDLE:
  - rx_s==0 -> START, counter=0.
  - Otherwise stay in IDLE.
- START (counter increments each cycle):
  - At counter==HALF_TICKS-1 with rx_s==0 -> DATA, counter=0, bit index=0.
  - At counter==HALF_TICKS-1 with rx_s==1 -> treat as a glitch, return to IDLE with no outputs.
- DATA:
  - At counter==BIT_TICKS-1, shift right with rx_s entering bit 7 (LSB-first on the line), then counter=0.
  - After the 8th sample (bit index 7) -> STOP. Otherwise bit index increments.
- STOP:
  - At counter==BIT_TICKS-1 with rx_s==1: data<=shift register, valid=1 for the next cycle only, -> IDLE.
  - At counter==BIT_TICKS-1 with rx_s==0: framing_error=1 for one cycle, data unchanged, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. This prevents a held-low line (break condition) from being decoded as repeated 0x00 frames.
- Latency: valid goes high 1 cycle after the stop-bit sample. That is 2 + 1 + (HALF_TICKS) + 9*BIT_TICKS cycles after the falling edge of RxD, within ±1 cycle.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start bit immediately after the stop bit is detected. No idle time between frames is needed.
- valid and framing_error are mutually exclusive. Neither is ever high for two consecutive cycles.
- Reset mid-frame: the frame is abandoned, nothing is emitted, and data returns to 0x00. A later falling edge on the line starts a new frame normally.
- Counter width: clog2(BIT_TICKS). It never wraps, because it is cleared at each terminal count.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE, START, DATA, STOP, BREAK (3 bits)
  - frame constants: DATA_BITS=8, STOP_BITS=1
  - tick-count function used by both the transmitter and the receiver
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value 1. It is reusable for the btn inputs.

Test Plan:
All scenarios use CLK_FREQ=16 and BAUD=1, so BIT_TICKS=16 and HALF_TICKS=8.
- Drive frame 0xA5 (start, then 1,0,1,0,0,1,0,1, then stop) -> exactly one valid pulse, data=0xA5, framing_error stays 0, busy falls on the same cycle valid rises.
- Send frames 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses 160 cycles apart, with data=0x00 and then data=0xFF.
- Pulse RxD low for 3 cycles, then hold it high -> no valid and no framing_error; busy high for at most 11 cycles, then IDLE.
- Send 0x3C with the stop bit forced low and the line held low for 40 more cycles -> one framing_error pulse, data keeps its prior value, no further pulses until the line goes high. A following 0x12 frame then decodes correctly.
- Assert reset for 1 cycle during data bit 4 of 0x5A, then send 0xC3 -> no output for 0x5A, data=0x00 right after reset, then valid with data=0xC3.
- Loopback: the transmitter's TxD drives RxD with sw=0x3C and a transmit pulse, at matching parameters -> valid with data=0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART state encoding, frame constants and baud helper.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per bit period; shared by transmitter and receiver.
    function automatic int tick_count(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer that resets to logic 1 (line idle).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver with mid-bit sampling and framing check.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int BIT_TICKS  = tick_count(CLK_FREQ, BAUD);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS);
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (RxD),
        .sync_out (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    // Re-check the start bit at its midpoint to reject glitches.
                    if (r_cnt == C_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == C_IDX_LAST) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start bit be seen.
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data          = r_data;
    assign valid         = r_valid;
    assign framing_error = r_ferr;
    assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Directed self-checking bench for uart_receiver (16 ticks/bit).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;

    logic       clk;
    logic       reset;
    logic       RxD;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_fe = 0;
    int n_both = 0;
    int n_double = 0;
    int n_busy = 0;
    int valid_cyc = 0;
    int prev_valid_cyc = 0;
    logic busy_at_valid = 1'b0;
    logic busy_before_valid = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_fe = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] data_hist[$];

    uart_receiver #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RxD           (RxD),
        .data          (data),
        .valid         (valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            prev_valid_cyc    = valid_cyc;
            valid_cyc         = cyc;
            busy_at_valid     = busy;
            busy_before_valid = prev_busy;
            data_hist.push_back(data);
        end
        if (framing_error) n_fe++;
        if (busy) n_busy++;
        if (valid && framing_error) n_both++;
        if ((valid && prev_valid) || (framing_error && prev_fe)) n_double++;
        prev_valid = valid;
        prev_fe    = framing_error;
        prev_busy  = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_level(input logic b, input int n);
        RxD = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_level(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_level(b[i], 16);
        drive_level(stop_bit, 16);
    endtask

    int v0, f0, b0, start_cyc, lat;

    initial begin
        reset = 1'b1;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  {24'h0, data}, 32'h00);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_ferr",  {31'h0, framing_error}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        reset = 1'b0;
        drive_level(1'b1, 5);

        // Single frame 0xA5
        v0 = n_valid; f0 = n_fe;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        drive_level(1'b1, 20);
        lat = valid_cyc - start_cyc;
        check("a5_count",  n_valid - v0, 1);
        check("a5_data",   {24'h0, data_hist[$]}, 32'hA5);
        check("a5_ferr",   n_fe - f0, 0);
        check("a5_lat",    (lat >= 154 && lat <= 156) ? 32'd1 : 32'd0, 32'd1);
        check("a5_busy_at_valid", {31'h0, busy_at_valid}, 32'h0);
        check("a5_busy_before",   {31'h0, busy_before_valid}, 32'h1);

        // Back-to-back 0x00, 0xFF
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_level(1'b1, 20);
        check("b2b_count", n_valid - v0, 2);
        check("b2b_first", {24'h0, data_hist[$-1]}, 32'h00);
        check("b2b_second", {24'h0, data_hist[$]}, 32'hFF);
        check("b2b_gap",   valid_cyc - prev_valid_cyc, 160);

        // Start-bit glitch
        v0 = n_valid; f0 = n_fe; b0 = n_busy;
        drive_level(1'b0, 3);
        drive_level(1'b1, 30);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr",  n_fe - f0, 0);
        check("glitch_busy_len", ((n_busy - b0) >= 1 && (n_busy - b0) <= 11) ? 32'd1 : 32'd0, 32'd1);
        check("glitch_idle",  {31'h0, busy}, 32'h0);

        // Framing error followed by held-low break, then recovery
        v0 = n_valid; f0 = n_fe;
        send_frame(8'h3C, 1'b0);
        drive_level(1'b0, 40);
        check("brk_ferr",   n_fe - f0, 1);
        check("brk_valid",  n_valid - v0, 0);
        check("brk_data",   {24'h0, data}, 32'hFF);
        check("brk_busy",   {31'h0, busy}, 32'h1);
        drive_level(1'b1, 10);
        check("brk_idle",   {31'h0, busy}, 32'h0);
        check("brk_ferr_after", n_fe - f0, 1);
        v0 = n_valid;
        send_frame(8'h12, 1'b1);
        drive_level(1'b1, 20);
        check("post_brk_count", n_valid - v0, 1);
        check("post_brk_data",  {24'h0, data_hist[$]}, 32'h12);

        // Reset during data bit 4 of 0x5A, then 0xC3
        v0 = n_valid; f0 = n_fe;
        drive_level(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_level(logic'((8'h5A >> i) & 8'h01), 16);
        drive_level(1'b1, 8);
        reset = 1'b1;
        RxD   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_data", {24'h0, data}, 32'h00);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        drive_level(1'b1, 200);
        check("rst_mid_valid", n_valid - v0, 0);
        check("rst_mid_ferr",  n_fe - f0, 0);
        send_frame(8'hC3, 1'b1);
        drive_level(1'b1, 20);
        check("c3_count", n_valid - v0, 1);
        check("c3_data",  {24'h0, data_hist[$]}, 32'hC3);

        // Loopback: transmitter waveform for sw=0x3C
        v0 = n_valid;
        send_frame(8'h3C, 1'b1);
        drive_level(1'b1, 20);
        check("loop_count", n_valid - v0, 1);
        check("loop_data",  {24'h0, data_hist[$]}, 32'h3C);

        check("excl_valid_ferr", n_both, 0);
        check("no_double_pulse", n_double, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
